// File: rtl/dsp_config_loader.sv
// Serial configuration writer: streams host words MSB-first into a daisy-chained slice, optionally comparing returned bits.
// States: S_IDLE waits for start | S_LOAD accepts and shifts words | S_DONE one-cycle completion pulse.
module dsp_config_loader #(
    parameter int CHAIN_LEN = 100,
    parameter int WORD_W    = 32,
    parameter int IDX_W     = 7
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              configuration_enable,
    output logic              configuration_input,
    input  logic              configuration_output,
    output logic              busy,
    output logic              done,
    output logic              verify_err,
    output logic [IDX_W-1:0]  err_index
);

    localparam int CNT_W = IDX_W + 1;
    localparam int WC_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] CHAIN_END  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CHAIN_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [WC_W-1:0]  WORD_CNT   = WC_W'(WORD_W);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bcnt;
    logic [WC_W-1:0]   wcnt;
    logic [WORD_W-1:0] shreg;
    logic              mode_verify;
    logic [CNT_W-1:0]  remaining;
    logic [WC_W-1:0]   load_len;
    logic              accept;
    logic              mismatch;

    // Last word is truncated so bits past the chain end are never shifted.
    always_comb begin
        remaining = CHAIN_END - bcnt;
        if (int'(remaining) >= WORD_W)
            load_len = WORD_CNT;
        else
            load_len = WC_W'(remaining);
    end

    always_comb begin
        state_nxt            = state;
        s_ready              = (state == S_LOAD) && (wcnt == '0) && (bcnt < CHAIN_END);
        configuration_enable = (state == S_LOAD) && (wcnt != '0);
        configuration_input  = shreg[WORD_W-1];
        busy                 = (state != S_IDLE);
        done                 = (state == S_DONE);
        accept               = s_valid && s_ready;
        mismatch             = configuration_output != configuration_input;
        case (state)
            S_IDLE: if (start) state_nxt = S_LOAD;
            S_LOAD: if (configuration_enable && (bcnt == CHAIN_LAST)) state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= S_IDLE;
            bcnt        <= '0;
            wcnt        <= '0;
            shreg       <= '0;
            mode_verify <= 1'b0;
            verify_err  <= 1'b0;
            err_index   <= '0;
        end else begin
            state <= state_nxt;
            if ((state == S_IDLE) && start) begin
                bcnt        <= '0;
                wcnt        <= '0;
                mode_verify <= verify;
                verify_err  <= 1'b0;
                err_index   <= '0;
            end else if (accept) begin
                shreg <= s_data;
                wcnt  <= load_len;
            end else if (configuration_enable) begin
                shreg <= {shreg[WORD_W-2:0], 1'b0};
                wcnt  <= wcnt - 1'b1;
                bcnt  <= bcnt + 1'b1;
                // Only the first mismatch of a pass is recorded.
                if (mode_verify && mismatch && !verify_err) begin
                    verify_err <= 1'b1;
                    err_index  <= bcnt[IDX_W-1:0];
                end
            end
        end
    end

endmodule

// File: doc/dsp_config_loader.md
# dsp_config_loader

Serial configuration writer for the APIR-DSP slice configuration chain. It takes configuration words from a host over a valid/ready stream and shifts them, MSB-first, into a daisy-chained slice through `configuration_input` and `configuration_enable`. It is the driving end of the chain protocol whose far end returns `configuration_output`. An optional verify pass re-streams the same image and compares each returned chain bit against the bit being sent.

## Interface
Parameters:
- `CHAIN_LEN`, default 100: total configuration bits in the chain. The default covers one pattern-detection slice: 48 + 1 + 2 + 1 + 48.
- `WORD_W`, default 32: host word width.
- `IDX_W`, default 7: width of the bit index; must satisfy 2^IDX_W ≥ CHAIN_LEN.

Ports (one clock `clk`; reset `RST` is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `RST`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a pass; sampled only in IDLE.
- `verify`  in  1  pass mode, sampled with `start`: 0 = load, 1 = load and compare.
- `s_data`  in  WORD_W  configuration word; bit WORD_W-1 is shifted first.
- `s_valid`  in  1  `s_data` is valid.
- `s_ready`  out  1  loader accepts a word this cycle.
- `configuration_enable`  out  1  chain shift enable.
- `configuration_input`  out  1  serial bit into the chain.
- `configuration_output`  in  1  serial bit returned from the chain tail.
- `busy`  out  1  a pass is in progress.
- `done`  out  1  one-cycle pulse when a pass completes.
- `verify_err`  out  1  sticky: a compare mismatch occurred in the current or last verify pass.
- `err_index`  out  IDX_W  stream index of the first mismatching bit.

## Operation
- States:
  - IDLE → LOAD on `start`.
  - LOAD → DONE when bit counter `bcnt` reaches CHAIN_LEN.
  - DONE → IDLE unconditionally. DONE lasts one cycle and asserts `done`.
- On the start edge:
  - `bcnt` = 0 and word-bit counter `wcnt` = 0.
  - Mode latched from `verify`.
  - `verify_err` and `err_index` cleared.
- `start` is ignored outside IDLE.
- `s_ready` = (state == LOAD) && (wcnt == 0) && (bcnt < CHAIN_LEN).
- On `s_valid && s_ready`:
  - `s_data` is loaded into shift register `shreg`.
  - `wcnt` = min(WORD_W, CHAIN_LEN − bcnt).
- Shift behaviour:
  - `configuration_enable` = (state == LOAD) && (wcnt != 0).
  - `configuration_input` = shreg[WORD_W-1].
  - Each enabled cycle: `shreg` shifts left, `wcnt`−1, `bcnt`+1.
- Stream bit k (k = 0 is the first bit shifted) ends at chain depth CHAIN_LEN−1−k. Bit 0 lands at the chain's last register.
- Final word: bits beyond CHAIN_LEN are discarded, never shifted.
- Gaps (`s_valid` low): `configuration_enable` stays 0 and the chain holds. Gaps are legal anywhere.
- Verify mode:
  - In each enabled cycle, compare `configuration_output` against `configuration_input`. The chain returns the bit shifted CHAIN_LEN enables earlier, so re-streaming the same image must match bit for bit.
  - On the first mismatch: `verify_err` ← 1 and `err_index` ← `bcnt`.
  - Later mismatches do not change `err_index`.
- Load mode performs no comparison; `verify_err` stays 0.
- `busy` = (state != IDLE).

## Timing
- Reset values: `s_ready` 0, `configuration_enable` 0, `configuration_input` 0, `busy` 0, `done` 0, `verify_err` 0, `err_index` 0. State is IDLE and all counters are 0.
- `start` sampled at edge n → LOAD in cycle n+1, and `s_ready` may assert in cycle n+1.
- A word accepted at edge m is shifted in cycles m+1 … m+WORD_W. The next `s_ready` is in cycle m+WORD_W+1, giving one bubble cycle per word.
- The last chain bit is shifted in cycle t. DONE and `done` = 1 follow in cycle t+1; IDLE and `busy` = 0 in cycle t+2.
- A new `start` is accepted from cycle t+2.
- `RST` mid-pass: after that edge all outputs take reset values and state is IDLE. Chain contents are partial, and the host must reload.
- `RST` and `start` in the same cycle: `RST` wins.

## Test plan
- Nominal load. CHAIN_LEN=100, WORD_W=32, `s_valid` held high, `start` at cycle 0.
  - Exactly 4 words accepted, at cycles 1, 34, 67 and 100.
  - 100 enable cycles; word 3 contributes only 4 bits.
  - `done` = 1 at cycle 105.
  - Chain model contents equal the bit-reversed stream.
- Valid gaps. Same image with `s_valid` low for 10 cycles before words 2 and 3.
  - `configuration_enable` is 0 during the gaps and the chain model is unchanged there.
  - `done` = 1 at cycle 125.
  - Final chain contents are identical to the nominal case.
- Verify pass.
  - Load image A, then verify with A: `verify_err` = 0.
  - Load A, then verify with A with stream bit 37 flipped: `verify_err` = 1 and `err_index` = 37.
  - The next `start` clears both.
- Reset mid-pass. Assert `RST` for one cycle after bit 50 is shifted.
  - Next cycle: `configuration_enable` = 0, `busy` = 0, `s_ready` = 0.
  - A fresh `start` then completes normally with `done` at cycle 105.
- Protocol guards.
  - `s_valid` = 1 while IDLE: no word consumed and no enable.
  - `start` pulsed while busy: ignored, with `bcnt` and word count unaffected.
  - `RST` and `start` in the same cycle: state stays IDLE.
